img_pxl_streamer: RTL and testbench

- Upstream feeder of the image resizer.
- Takes a raw raster-order pixel stream (data + start-of-frame marker, valid/ready) and a per-frame size configuration.
- Produces the resizer's input stream: pixel data plus PxlX/PxlY coordinates and ImgWidth/ImgHeight, behind a 2-entry registered skid buffer so neither side sees a combinational path.

---
 rtl/img_pxl_streamer.sv | 223 ++++++++++++++++++++++
 tb/tb_img_pxl_streamer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_pxl_streamer.sv
// Raster pixel feeder for the image resizer: tags raw pixels with X/Y and hands them on through a
// 2-entry registered skid buffer. Optional SOF checking is enabled by IMG_PXL_STREAMER_SOF_CHK_EN.
module img_pxl_streamer #(
  parameter int unsigned IMG_WIDTH_MAX_SIZE  = 1024,
  parameter int unsigned IMG_HEIGHT_MAX_SIZE = 1024,
  parameter int unsigned IMG_WIDTH_IDX_W     = $clog2(IMG_WIDTH_MAX_SIZE),
  parameter int unsigned IMG_HEIGHT_IDX_W    = $clog2(IMG_HEIGHT_MAX_SIZE),
  parameter int unsigned PXL_PRIM_COLOR_NUM  = 1,
  parameter int unsigned PXL_PRIM_COLOR_W    = 8
) (
  input  logic                                         Clk,
  input  logic                                         Reset,
  input  logic [IMG_WIDTH_IDX_W-1:0]                   CfgWidth,
  input  logic [IMG_HEIGHT_IDX_W-1:0]                  CfgHeight,
  input  logic                                         CfgVld,
  input  logic [PXL_PRIM_COLOR_NUM*PXL_PRIM_COLOR_W-1:0] InPxlDat,
  input  logic                                         InSof,
  input  logic                                         InVld,
  output logic                                         InRdy,
  output logic [IMG_WIDTH_IDX_W-1:0]                   ImgWidth,
  output logic [IMG_HEIGHT_IDX_W-1:0]                  ImgHeight,
  output logic [PXL_PRIM_COLOR_W-1:0]                  PxlData [PXL_PRIM_COLOR_NUM],
  output logic [IMG_WIDTH_IDX_W-1:0]                   PxlX,
  output logic [IMG_HEIGHT_IDX_W-1:0]                  PxlY,
  output logic                                         PxlVld,
  input  logic                                         PxlRdy,
  output logic                                         FrmDone,
  output logic                                         SofErr
);
  localparam int unsigned DatW = PXL_PRIM_COLOR_NUM * PXL_PRIM_COLOR_W;
  localparam int unsigned XW   = IMG_WIDTH_IDX_W;
  localparam int unsigned YW   = IMG_HEIGHT_IDX_W;
  localparam logic [XW-1:0] XOne = XW'(1);
  localparam logic [YW-1:0] YOne = YW'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;
  state_e state_q, state_d;

  logic [XW-1:0]   width_q, width_d, x_last_q, x_last_d, x_q, x_d, eff_x;
  logic [YW-1:0]   height_q, height_d, y_last_q, y_last_d, y_q, y_d, eff_y;
  logic [DatW-1:0] buf_dat_q [2];
  logic [DatW-1:0] buf_dat_d [2];
  logic [XW-1:0]   buf_x_q [2];
  logic [XW-1:0]   buf_x_d [2];
  logic [YW-1:0]   buf_y_q [2];
  logic [YW-1:0]   buf_y_d [2];
  logic [1:0]      buf_last_q, buf_last_d, cnt_q, cnt_d;
  logic            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            frm_done_q, frm_done_d;
  logic            accept, push, pop, pxl_last;

  assign accept   = (state_q == StRun) && InVld && (cnt_q != 2'd2);
  assign pop      = (cnt_q != 2'd0) && PxlRdy;
  assign pxl_last = (eff_x == x_last_q) && (eff_y == y_last_q);

`ifdef IMG_PXL_STREAMER_SOF_CHK_EN
  logic at_origin, sof_err_q, sof_err_d, disc_q, disc_d;
  assign at_origin = (x_q == '0) && (y_q == '0);

  // disc_q remembers that a run of pre-SOF pixels is already being dropped, so SofErr fires once.
  always_comb begin
    push      = accept;
    eff_x     = x_q;
    eff_y     = y_q;
    sof_err_d = 1'b0;
    disc_d    = (state_q == StIdle) ? 1'b0 : disc_q;
    if (accept) begin
      if (at_origin && !InSof) begin
        push      = 1'b0;
        sof_err_d = !disc_q;
        disc_d    = 1'b1;
      end else begin
        disc_d = 1'b0;
        if (InSof && !at_origin) begin
          sof_err_d = 1'b1;
          eff_x     = '0;
          eff_y     = '0;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sof_err_q <= 1'b0;
      disc_q    <= 1'b0;
    end else begin
      sof_err_q <= sof_err_d;
      disc_q    <= disc_d;
    end
  end
  assign SofErr = sof_err_q;
`else
  logic unused_sof;
  assign unused_sof = InSof;
  assign push       = accept;
  assign eff_x      = x_q;
  assign eff_y      = y_q;
  assign SofErr     = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    height_d = height_q;
    x_last_d = x_last_q;
    y_last_d = y_last_q;
    x_d      = x_q;
    y_d      = y_q;
    case (state_q)
      StIdle: begin
        if (CfgVld && (CfgWidth != '0) && (CfgHeight != '0)) begin
          width_d  = CfgWidth;
          height_d = CfgHeight;
          x_last_d = CfgWidth - XOne;
          y_last_d = CfgHeight - YOne;
          x_d      = '0;
          y_d      = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        if (push) begin
          if (pxl_last) begin
            x_d     = '0;
            y_d     = '0;
            state_d = StDrain;
          end else if (eff_x == x_last_q) begin
            x_d = '0;
            y_d = eff_y + YOne;
          end else begin
            x_d = eff_x + XOne;
            y_d = eff_y;
          end
        end
      end
      StDrain: begin
        if (pop && buf_last_q[rd_ptr_q]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    buf_dat_d  = buf_dat_q;
    buf_x_d    = buf_x_q;
    buf_y_d    = buf_y_q;
    buf_last_d = buf_last_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    if (push) begin
      buf_dat_d[wr_ptr_q]  = InPxlDat;
      buf_x_d[wr_ptr_q]    = eff_x;
      buf_y_d[wr_ptr_q]    = eff_y;
      buf_last_d[wr_ptr_q] = pxl_last;
      wr_ptr_d             = !wr_ptr_q;
    end
    if (pop) rd_ptr_d = !rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    frm_done_d = pop && buf_last_q[rd_ptr_q];
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      width_q    <= '0;
      height_q   <= '0;
      x_last_q   <= '0;
      y_last_q   <= '0;
      x_q        <= '0;
      y_q        <= '0;
      for (int i = 0; i < 2; i++) begin
        buf_dat_q[i] <= '0;
        buf_x_q[i]   <= '0;
        buf_y_q[i]   <= '0;
      end
      buf_last_q <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= '0;
      frm_done_q <= 1'b0;
    end else begin
      width_q    <= width_d;
      height_q   <= height_d;
      x_last_q   <= x_last_d;
      y_last_q   <= y_last_d;
      x_q        <= x_d;
      y_q        <= y_d;
      buf_dat_q  <= buf_dat_d;
      buf_x_q    <= buf_x_d;
      buf_y_q    <= buf_y_d;
      buf_last_q <= buf_last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      frm_done_q <= frm_done_d;
    end
  end

  always_comb begin
    InRdy  = (state_q == StRun) && (cnt_q != 2'd2);
    PxlVld = (cnt_q != 2'd0);
    PxlX   = buf_x_q[rd_ptr_q];
    PxlY   = buf_y_q[rd_ptr_q];
    for (int c = 0; c < int'(PXL_PRIM_COLOR_NUM); c++) begin
      PxlData[c] = buf_dat_q[rd_ptr_q][c*PXL_PRIM_COLOR_W +: PXL_PRIM_COLOR_W];
    end
  end

  assign ImgWidth  = width_q;
  assign ImgHeight = height_q;
  assign FrmDone   = frm_done_q;

endmodule

// File: tb/tb_img_pxl_streamer.sv
// Self-checking bench for img_pxl_streamer: table/loop-driven frames with a scoreboard queue.
// SOF-check scenarios run only when IMG_PXL_STREAMER_SOF_CHK_EN is defined.
module tb_img_pxl_streamer;
  logic       Clk, Reset;
  logic [9:0] CfgWidth, CfgHeight;
  logic       CfgVld;
  logic [7:0] InPxlDat;
  logic       InSof, InVld, InRdy;
  logic [9:0] ImgWidth, ImgHeight;
  logic [7:0] PxlData [1];
  logic [9:0] PxlX, PxlY;
  logic       PxlVld, PxlRdy, FrmDone, SofErr;

  img_pxl_streamer dut (
    .Clk(Clk), .Reset(Reset), .CfgWidth(CfgWidth), .CfgHeight(CfgHeight), .CfgVld(CfgVld),
    .InPxlDat(InPxlDat), .InSof(InSof), .InVld(InVld), .InRdy(InRdy), .ImgWidth(ImgWidth),
    .ImgHeight(ImgHeight), .PxlData(PxlData), .PxlX(PxlX), .PxlY(PxlY), .PxlVld(PxlVld),
    .PxlRdy(PxlRdy), .FrmDone(FrmDone), .SofErr(SofErr)
  );

  typedef struct { logic [7:0] dat; logic sof; logic [9:0] x; logic [9:0] y; } vec_t;
  typedef struct { logic [7:0] dat; logic [9:0] x; logic [9:0] y; } exp_t;

  exp_t exp_q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, occ = 0, frm_cnt = 0, sof_cnt = 0;
  int   first_acc_cyc = -1, last_acc_cyc = -1, first_out_cyc = -1, last_hs_cyc = -1000;
  bit   sending = 0, cur_emit = 1, prev_stall = 0;
  logic [27:0] prev_out;
  int   rdy_mode = 0, ph = 0;
  logic [3:0] rdy_pat = 4'b1001;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  always @(posedge Clk) begin
    #1;
    case (rdy_mode)
      0:       PxlRdy = 1'b1;
      1:       begin PxlRdy = rdy_pat[ph]; ph = (ph + 1) % 4; end
      default: PxlRdy = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops, occupancy model, stall stability, pulse counting.
  always @(negedge Clk) begin
    exp_t e;
    if (!Reset) begin
      occ = 0;
      prev_stall = 0;
    end else begin
      if (FrmDone) begin
        frm_cnt++;
        chk("frmdone_timing", cyc, last_hs_cyc + 1);
      end
      if (SofErr) sof_cnt++;
      chk("pxlvld_occ", PxlVld, occ != 0);
      if (sending) chk("inrdy_occ", InRdy, occ < 2);
      if (prev_stall) begin
        chk("stall_vld", PxlVld, 1'b1);
        chk("stall_hold", {PxlData[0], PxlX, PxlY}, prev_out);
      end
      if (PxlVld && PxlRdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h at (%0d,%0d) expected none",
                   PxlData[0], PxlX, PxlY);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", PxlData[0], e.dat);
          chk("out_x", PxlX, e.x);
          chk("out_y", PxlY, e.y);
        end
        if (first_out_cyc < 0) first_out_cyc = cyc;
        last_hs_cyc = cyc;
      end
      prev_stall = PxlVld && !PxlRdy;
      prev_out   = {PxlData[0], PxlX, PxlY};
      occ = occ + int'(InVld && InRdy && cur_emit) - int'(PxlVld && PxlRdy);
    end
  end

  task automatic cfg(input int w, input int h, input bit hold);
    int t = 0;
    CfgWidth = 10'(w); CfgHeight = 10'(h); CfgVld = 1'b1;
    do begin @(posedge Clk); #1; t++; end while (!InRdy && t < 10);
    chk("cfg_enter_run", InRdy, 1'b1);
    if (!hold) CfgVld = 1'b0;
    sending = 1'b1;
  endtask

  task automatic send_px(input logic [7:0] dat, input logic sof, input logic [9:0] ex,
                         input logic [9:0] ey, input bit emit);
    int t = 0;
    bit acc;
    InVld = 1'b1; InPxlDat = dat; InSof = sof; cur_emit = emit;
    do begin
      @(negedge Clk);
      acc = InRdy;
      t++;
      if (acc) begin
        if (emit) exp_q.push_back('{dat, ex, ey});
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
      end
      @(posedge Clk); #1;
    end while (!acc && t < 200);
    chk("accept_timeout", acc, 1'b1);
  endtask

  task automatic send_frame(input int w, input int h, input logic [7:0] base, input logic sof0);
    for (int i = 0; i < w * h; i++)
      send_px(base + 8'(i), (i == 0) ? sof0 : 1'b0, 10'(i % w), 10'(i / w), 1'b1);
    InVld = 1'b0; sending = 1'b0; cur_emit = 1'b1;
  endtask

  task automatic wait_frame();
    int t = 0;
    do begin @(negedge Clk); t++; end while (!FrmDone && t < 300);
    chk("frmdone_seen", FrmDone, 1'b1);
  endtask

  task automatic end_frame(input int frm0);
    wait_frame();
    repeat (3) @(posedge Clk);
    #1;
    chk("frmdone_count", frm_cnt - frm0, 1);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    vec_t tbl [8];
    int frm0, sof0;
    tbl[0] = '{8'h10, 1'b1, 10'd0, 10'd0}; tbl[1] = '{8'h11, 1'b0, 10'd1, 10'd0};
    tbl[2] = '{8'h12, 1'b0, 10'd2, 10'd0}; tbl[3] = '{8'h13, 1'b0, 10'd3, 10'd0};
    tbl[4] = '{8'h14, 1'b0, 10'd0, 10'd1}; tbl[5] = '{8'h15, 1'b0, 10'd1, 10'd1};
    tbl[6] = '{8'h16, 1'b0, 10'd2, 10'd1}; tbl[7] = '{8'h17, 1'b0, 10'd3, 10'd1};

    Reset = 1'b1; CfgWidth = '0; CfgHeight = '0; CfgVld = 1'b0;
    InPxlDat = '0; InSof = 1'b0; InVld = 1'b0;
    #2 Reset = 1'b0;
    #1;
    chk("rst_inrdy", InRdy, 0);      chk("rst_pxlvld", PxlVld, 0);
    chk("rst_pxlx", PxlX, 0);        chk("rst_pxly", PxlY, 0);
    chk("rst_pxldata", PxlData[0], 0);
    chk("rst_imgw", ImgWidth, 0);    chk("rst_imgh", ImgHeight, 0);
    chk("rst_frmdone", FrmDone, 0);  chk("rst_soferr", SofErr, 0);
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1 chk("idle_inrdy", InRdy, 0);

    // 4x2 back-to-back, PxlRdy held high
    rdy_mode = 0;
    frm0 = frm_cnt;
    cfg(4, 2, 0);
    chk("cfg_imgw", ImgWidth, 4);
    chk("cfg_imgh", ImgHeight, 2);
    first_acc_cyc = -1; first_out_cyc = -1;
    for (int i = 0; i < 8; i++) send_px(tbl[i].dat, tbl[i].sof, tbl[i].x, tbl[i].y, 1'b1);
    InVld = 1'b0; sending = 1'b0;
    end_frame(frm0);
    chk("latency", first_out_cyc, first_acc_cyc + 1);
    chk("in_throughput", last_acc_cyc - first_acc_cyc, 7);
    chk("out_throughput", last_hs_cyc - first_out_cyc, 7);
    chk("hold_imgw", ImgWidth, 4);
    chk("hold_imgh", ImgHeight, 2);

    // Same frame with 1,0,0,1 back-pressure
    rdy_mode = 1;
    frm0 = frm_cnt;
    cfg(4, 2, 0);
    for (int i = 0; i < 8; i++) send_px(tbl[i].dat, tbl[i].sof, tbl[i].x, tbl[i].y, 1'b1);
    InVld = 1'b0; sending = 1'b0;
    end_frame(frm0);
    rdy_mode = 0;

    // Zero-width config is ignored
    CfgWidth = 10'd0; CfgHeight = 10'd5; CfgVld = 1'b1;
    @(posedge Clk); #1 CfgVld = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      chk("zero_cfg_inrdy", InRdy, 0);
      chk("zero_cfg_imgw", ImgWidth, 4);
    end
    @(posedge Clk); #1;
    frm0 = frm_cnt;
    cfg(3, 3, 0);
    chk("cfg3_imgw", ImgWidth, 3);
    send_frame(3, 3, 8'h30, 1'b1);
    end_frame(frm0);

    // Reset mid-frame
    rdy_mode = 1;
    cfg(4, 2, 0);
    for (int i = 0; i < 5; i++) send_px(tbl[i].dat, tbl[i].sof, tbl[i].x, tbl[i].y, 1'b1);
    chk("pre_reset_vld", PxlVld, 1);
    #1 Reset = 1'b0; InVld = 1'b0; sending = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_pxlvld", PxlVld, 0);  chk("midrst_inrdy", InRdy, 0);
    chk("midrst_pxlx", PxlX, 0);      chk("midrst_pxly", PxlY, 0);
    chk("midrst_data", PxlData[0], 0); chk("midrst_imgw", ImgWidth, 0);
    rdy_mode = 0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk); #1;
    frm0 = frm_cnt;
    cfg(2, 2, 0);
    chk("postrst_imgw", ImgWidth, 2);
    send_frame(2, 2, 8'h60, 1'b1);
    end_frame(frm0);

`ifdef IMG_PXL_STREAMER_SOF_CHK_EN
    // Leading pixels without SOF are dropped
    frm0 = frm_cnt; sof0 = sof_cnt;
    cfg(4, 2, 0);
    send_px(8'h01, 1'b0, 10'd0, 10'd0, 1'b0);
    send_px(8'h02, 1'b0, 10'd0, 10'd0, 1'b0);
    send_frame(4, 2, 8'hA0, 1'b1);
    end_frame(frm0);
    chk("sof_lead_pulses", sof_cnt - sof0, 1);
    // Mid-frame SOF restarts the frame
    frm0 = frm_cnt; sof0 = sof_cnt;
    cfg(4, 2, 0);
    send_px(8'hB0, 1'b1, 10'd0, 10'd0, 1'b1);
    send_px(8'hB1, 1'b0, 10'd1, 10'd0, 1'b1);
    send_frame(4, 2, 8'hC0, 1'b1);
    end_frame(frm0);
    chk("sof_mid_pulses", sof_cnt - sof0, 1);
`else
    // SOF is ignored: first pixel after config is (0,0) regardless
    frm0 = frm_cnt;
    cfg(2, 2, 0);
    send_frame(2, 2, 8'h70, 1'b0);
    end_frame(frm0);
    chk("soferr_never", sof_cnt, 0);
`endif

    // Back-to-back frames with CfgVld held high
    frm0 = frm_cnt;
    cfg(2, 2, 1);
    send_frame(2, 2, 8'h80, 1'b1);
    wait_frame();
    chk("b2b_idle_inrdy", InRdy, 0);
    @(negedge Clk);
    chk("b2b_run_inrdy", InRdy, 1);
    chk("b2b_imgw", ImgWidth, 2);
    @(posedge Clk); #1;
    sending = 1'b1;
    send_frame(2, 2, 8'h90, 1'b1);
    CfgVld = 1'b0;
    end_frame(frm0 + 1);
    chk("b2b_frm_total", frm_cnt - frm0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1);
  end
endmodule
